vend_ctrl_multi: RTL
====================

Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-clock vending controller.
- Supports NUM_PRODUCTS products, each with its own price and stock counter.
- Adds saturating credit, a cancel/refund path and restock.
- Change is paid as a multi-coin greedy sequence, one coin pulse per cycle, driven by a small FSM.
- Sits between the coin acceptor / keypad front-end and the dispenser and change-hopper drivers.

Parameters:
- NUM_PRODUCTS, 3: number of product channels.
- CREDIT_W, 8: width of the credit register.
- STOCK_W, 2: width of each per-product stock counter.
- PRICES, {8'd45,8'd25,8'd15}: packed NUM_PRODUCTS×CREDIT_W price vector; index 0 in the LSBs; every price is a multiple of 5.
- INIT_STOCK, 2: stock loaded at reset and on restock; must fit in STOCK_W bits.
- MAX_CREDIT, 200: credit ceiling; must be a multiple of 5 and below 2^CREDIT_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- coin_in  in  4  one-hot coin strobe; bit0=5, bit1=10, bit2=20, bit3=50.
- select  in  NUM_PRODUCTS  product request strobes.
- cancel  in  1  refund the whole credit.
- restock  in  1  reload every stock counter to INIT_STOCK.
- dispense  out  NUM_PRODUCTS  one-cycle vend pulse, at most one bit set.
- change_coin  out  4  one-cycle change-coin pulse, same encoding as coin_in, at most one bit set.
- coin_reject  out  1  one-cycle pulse: the inserted coin is returned uncredited.
- err_stock  out  1  one-cycle pulse: selected product is empty.
- err_funds  out  1  one-cycle pulse: credit is insufficient.
- out_of_stock  out  NUM_PRODUCTS  level; bit i is set when stock i == 0.
- busy  out  1  level; high while in the CHANGE state.
- credit  out  CREDIT_W  current credit, registered.

Behaviour:
- Reset (reset_n low at a clk edge):
  - credit=0; all stock = INIT_STOCK; state=IDLE.
  - All pulse outputs 0; busy=0; out_of_stock=0.
  - Reset overrides everything, including a change sequence in progress; undelivered change is lost.
- Outputs are registered. Pulse outputs default to 0 every cycle.
- States: IDLE, CHANGE.
- IDLE, coin handling:
  - Legal coin: coin_in one-hot and credit + value ≤ MAX_CREDIT.
  - A legal coin adds its value to eff = credit + value. Otherwise eff = credit.
  - A multi-hot coin_in, or a coin that would exceed MAX_CREDIT, gives coin_reject=1 and no credit.
- IDLE, priority when several inputs are active in the same cycle: cancel > select > coin-only.
- IDLE, cancel:
  - If eff > 0: remaining = eff, credit <= 0, go to CHANGE.
  - If eff == 0: no action.
- IDLE, select (lowest set index i wins; other select bits are ignored):
  - stock[i] == 0: err_stock=1; credit <= eff.
  - eff < PRICES[i]: err_funds=1; credit <= eff.
  - Otherwise: dispense[i]=1, stock[i] decrements, credit <= 0, remaining = eff − PRICES[i].
  - After a vend, go to CHANGE if remaining > 0, else stay in IDLE.
- CHANGE state:
  - busy=1.
  - Each cycle, pulse the largest denomination ≤ remaining (order 50, 20, 10, 5) and subtract it from remaining.
  - Return to IDLE in the cycle after remaining reaches 0.
  - Example: remaining 35 gives 20, then 10, then 5 on three consecutive cycles; busy is high for exactly those 3 cycles.
  - Any coin_in during CHANGE gives coin_reject=1.
  - select and cancel are ignored during CHANGE; no error pulses.
- Restock:
  - Accepted in any state, with priority over a same-cycle decrement: all stock <= INIT_STOCK.
  - A same-cycle select still vends if it was legal before the restock.
- Latency:
  - Vend pulse appears 1 cycle after the select edge.
  - First change coin appears 1 cycle after the dispense pulse.
- Arithmetic:
  - Credit comparisons are unsigned at CREDIT_W+1 bits; credit can never wrap.
  - Stock never decrements below 0.
- out_of_stock[i] is registered from the stock register and updates 1 cycle after the stock changes.

Decomposition:
- Package vend_pkg holds:
  - the coin index enum (COIN_5, COIN_10, COIN_20, COIN_50);
  - the denomination value constants;
  - the state enum;
  - a function coin_value(onehot) that returns 0 for an illegal encoding.
- One sub-module: vend_change_gen.
  - Holds the remaining-change register.
  - Performs the greedy one-coin-per-cycle selection.
  - Handshake: a start pulse with an amount in, done out.
- The product price/stock logic stays in the top module as a generate loop.

Test Plan:
- Insert 10, then 5, then select[0] (price 15) → dispense[0] pulses 1 cycle later; credit=0; no change_coin; stock0 goes 2→1.
- Insert 50, then select[2] (price 45) → dispense[2]; next cycle change_coin=COIN_5; busy high for exactly 1 cycle.
- Insert 50, 20, 20, then select[1] (price 25) → change of 65 paid as 50, 10, 5 on 3 consecutive cycles; a coin_10 inserted mid-sequence gives coin_reject with credit unchanged.
- Vend product 0 twice, then select[0] with credit 20 → err_stock pulse; out_of_stock[0]=1; credit stays 20; restock → out_of_stock[0] clears the following cycle.
- Credit 190, then coin_20 → coin_reject; credit stays 190. coin_in=4'b0011 → coin_reject. cancel → change pulses 50, 50, 50, 20, 20; credit=0.
- reset_n low while in CHANGE with remaining 30 → next cycle: all outputs 0, state IDLE, credit 0, stock back to INIT_STOCK.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package vend_pkg;

  // Bit position of each denomination in the one-hot coin vectors.
  typedef enum logic [1:0] {
    COIN_5  = 2'd0,
    COIN_10 = 2'd1,
    COIN_20 = 2'd2,
    COIN_50 = 2'd3
  } coin_idx_e;

  localparam logic [5:0] VAL_5  = 6'd5;
  localparam logic [5:0] VAL_10 = 6'd10;
  localparam logic [5:0] VAL_20 = 6'd20;
  localparam logic [5:0] VAL_50 = 6'd50;

  typedef enum logic {
    ST_IDLE,
    ST_CHANGE
  } state_e;

  // One-hot strobe for a denomination index.
  function automatic logic [3:0] coin_onehot(input coin_idx_e c);
    return 4'b0001 << c;
  endfunction

  // Value of a coin strobe; anything other than exactly one bit is worth 0.
  function automatic logic [5:0] coin_value(input logic [3:0] onehot);
    case (onehot)
      4'b0001: return VAL_5;
      4'b0010: return VAL_10;
      4'b0100: return VAL_20;
      4'b1000: return VAL_50;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Front-end / driver side signal bundle of the vending controller.
// Latency: none (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse.
interface vend_ctrl_multi_if #(
  parameter int NUM_PRODUCTS = 3,
  parameter int CREDIT_W     = 8
);
  logic [3:0]              coin_in;
  logic [NUM_PRODUCTS-1:0] select;
  logic                    cancel;
  logic                    restock;
  logic [NUM_PRODUCTS-1:0] dispense;
  logic [3:0]              change_coin;
  logic                    coin_reject;
  logic                    err_stock;
  logic                    err_funds;
  logic [NUM_PRODUCTS-1:0] out_of_stock;
  logic                    busy;
  logic [CREDIT_W-1:0]     credit;

  // Coin acceptor / keypad side.
  modport master (
    output coin_in, select, cancel, restock,
    input  dispense, change_coin, coin_reject, err_stock, err_funds,
           out_of_stock, busy, credit
  );

  // Controller side.
  modport slave (
    input  coin_in, select, cancel, restock,
    output dispense, change_coin, coin_reject, err_stock, err_funds,
           out_of_stock, busy, credit
  );
endinterface

// File: rtl/vend_change_gen.sv
// Greedy change payer: one coin pulse per cycle, largest denomination first.
// Latency: first coin 1 cycle after start_i; done_o flags the cycle the last coin is chosen.
// Backpressure: none; start_i is only issued while idle and the sequence always runs to completion.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  output logic [3:0]          coin_o,
  output logic                busy_o,
  output logic                done_o
);

  logic [CREDIT_W-1:0] remaining_q, remaining_d, step;
  logic [3:0]          coin_q, coin_d;
  logic                busy_q;

  // Pick the largest coin that fits; a sub-5 residue (never expected) is dropped silently.
  always_comb begin
    coin_d = '0;
    step   = remaining_q;
    if (remaining_q >= CREDIT_W'(VAL_50)) begin
      coin_d = coin_onehot(COIN_50);
      step   = CREDIT_W'(VAL_50);
    end else if (remaining_q >= CREDIT_W'(VAL_20)) begin
      coin_d = coin_onehot(COIN_20);
      step   = CREDIT_W'(VAL_20);
    end else if (remaining_q >= CREDIT_W'(VAL_10)) begin
      coin_d = coin_onehot(COIN_10);
      step   = CREDIT_W'(VAL_10);
    end else if (remaining_q >= CREDIT_W'(VAL_5)) begin
      coin_d = coin_onehot(COIN_5);
      step   = CREDIT_W'(VAL_5);
    end
    remaining_d = remaining_q - step;
  end

  assign done_o = (remaining_q != '0) && (remaining_d == '0);

  // Load a new amount on start, otherwise pay one coin per cycle until empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remaining_q <= '0;
      coin_q      <= '0;
      busy_q      <= 1'b0;
    end else if (start_i) begin
      remaining_q <= amount_i;
      coin_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      busy_q      <= (remaining_q != '0);
    end
  end

  assign coin_o = coin_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit, per-product price/stock, cancel/refund, restock.
// Latency: all outputs registered; vend 1 cycle after select, first change coin 1 cycle after vend.
// Backpressure: none; inputs arriving while change is being paid are ignored (coins rejected).
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                                NUM_PRODUCTS = 3,
  parameter int                                CREDIT_W     = 8,
  parameter int                                STOCK_W      = 2,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]  PRICES       = {8'd45, 8'd25, 8'd15},
  parameter int                                INIT_STOCK   = 2,
  parameter int                                MAX_CREDIT   = 200
) (
  input logic               clk,
  input logic               reset_n,
  vend_ctrl_multi_if.slave  bus
);

  // Credit arithmetic is done one bit wider so a sum can never wrap silently.
  localparam int EW = CREDIT_W + 1;

  state_e                  state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [NUM_PRODUCTS-1:0] dispense_q, dispense_d;
  logic                    reject_q, reject_d;
  logic                    err_stock_q, err_stock_d;
  logic                    err_funds_q, err_funds_d;

  logic [EW-1:0]           credit_x, coin_val_x, sum_x, eff_x, sel_price;
  logic                    coin_any, coin_legal;
  logic [NUM_PRODUCTS-1:0] sel_oh, stock_nz, oos, dec_en;
  logic                    sel_any, sel_stock_ok;
  logic [CREDIT_W-1:0]     change_w;
  logic                    chg_start, chg_done;
  logic [CREDIT_W-1:0]     chg_amount;

  // Effective credit this cycle and the lowest-index select with its price/stock.
  always_comb begin
    credit_x     = {1'b0, credit_q};
    coin_val_x   = EW'(coin_value(bus.coin_in));
    coin_any     = |bus.coin_in;
    sum_x        = credit_x + coin_val_x;
    coin_legal   = (coin_val_x != '0) && (sum_x <= EW'(MAX_CREDIT));
    eff_x        = coin_legal ? sum_x : credit_x;
    sel_oh       = bus.select & (~bus.select + NUM_PRODUCTS'(1));
    sel_any      = |bus.select;
    sel_price    = '0;
    sel_stock_ok = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_oh[i]) begin
        sel_price    = EW'(PRICES[i*CREDIT_W +: CREDIT_W]);
        sel_stock_ok = stock_nz[i];
      end
    end
    change_w = eff_x[CREDIT_W-1:0] - sel_price[CREDIT_W-1:0];
  end

  // Next-state decisions: cancel beats select beats a plain coin.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    dispense_d  = '0;
    reject_d    = 1'b0;
    err_stock_d = 1'b0;
    err_funds_d = 1'b0;
    chg_start   = 1'b0;
    chg_amount  = '0;
    dec_en      = '0;
    case (state_q)
      ST_IDLE: begin
        reject_d = coin_any && !coin_legal;
        credit_d = eff_x[CREDIT_W-1:0];
        if (bus.cancel) begin
          if (eff_x != '0) begin
            credit_d   = '0;
            chg_start  = 1'b1;
            chg_amount = eff_x[CREDIT_W-1:0];
            state_d    = ST_CHANGE;
          end
        end else if (sel_any) begin
          if (!sel_stock_ok) begin
            err_stock_d = 1'b1;
          end else if (eff_x < sel_price) begin
            err_funds_d = 1'b1;
          end else begin
            dispense_d = sel_oh;
            dec_en     = sel_oh;
            credit_d   = '0;
            if (change_w != '0) begin
              chg_start  = 1'b1;
              chg_amount = change_w;
              state_d    = ST_CHANGE;
            end
          end
        end
      end
      ST_CHANGE: begin
        reject_d = coin_any;
        if (chg_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      dispense_q  <= '0;
      reject_q    <= 1'b0;
      err_stock_q <= 1'b0;
      err_funds_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      dispense_q  <= dispense_d;
      reject_q    <= reject_d;
      err_stock_q <= err_stock_d;
      err_funds_q <= err_funds_d;
    end
  end

  // Per-product stock counter and empty flag.
  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_prod
    logic [STOCK_W-1:0] stock_q;
    logic               oos_q;

    // Restock wins over a same-cycle vend; the vend itself was judged on the old count.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        stock_q <= STOCK_W'(INIT_STOCK);
        oos_q   <= 1'b0;
      end else begin
        if (bus.restock) begin
          stock_q <= STOCK_W'(INIT_STOCK);
        end else if (dec_en[g] && (stock_q != '0)) begin
          stock_q <= stock_q - STOCK_W'(1);
        end
        oos_q <= (stock_q == '0);
      end
    end

    assign stock_nz[g] = (stock_q != '0);
    assign oos[g]      = oos_q;
  end

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (chg_start),
    .amount_i (chg_amount),
    .coin_o   (bus.change_coin),
    .busy_o   (bus.busy),
    .done_o   (chg_done)
  );

  assign bus.dispense     = dispense_q;
  assign bus.coin_reject  = reject_q;
  assign bus.err_stock    = err_stock_q;
  assign bus.err_funds    = err_funds_q;
  assign bus.out_of_stock = oos;
  assign bus.credit       = credit_q;

endmodule
